// File: rtl/button_conditioner.sv
// Conditions raw push-button pins into debounced levels plus one-cycle press/release pulses,
// with optional hold-to-repeat press pulses for continuous actions.
module button_conditioner #(
   parameter int NUM_BTNS        = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release
);

   localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES);
   localparam int REP_MAX        = REPEAT_DELAY + REPEAT_PERIOD;
   localparam int REP_W          = $clog2(REP_MAX + 2);
   localparam bit REPEAT_ENABLE  = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   logic [NUM_BTNS-1:0] sync1_reg;
   logic [NUM_BTNS-1:0] sync2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
         state_t           state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic [REP_W-1:0] rep_cnt_reg;
         logic [REP_W-1:0] rep_next;
         logic             press_reg;
         logic             rel_reg;
         logic             level_reg;
         logic             s;

         assign s = sync2_reg[gi];

         // Repeat timer holds t; once past the first repeat it wraps back to
         // REPEAT_DELAY so every wrap lands on a pulse slot and never overflows.
         always_comb begin
            rep_next = rep_cnt_reg + REP_W'(1);
            if (rep_next == REP_W'(REP_MAX)) begin
               rep_next = REP_W'(REPEAT_DELAY);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_reg   <= IDLE;
               cnt_reg     <= '0;
               rep_cnt_reg <= '0;
               press_reg   <= 1'b0;
               rel_reg     <= 1'b0;
               level_reg   <= 1'b0;
            end else begin
               press_reg <= 1'b0;
               rel_reg   <= 1'b0;
               case (state_reg)
                  IDLE: begin
                     if (s) begin
                        state_reg <= DEB_PRESS;
                        cnt_reg   <= '0;
                     end
                  end
                  DEB_PRESS: begin
                     if (!s) begin
                        state_reg <= IDLE;
                     end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_reg   <= PRESSED;
                        press_reg   <= 1'b1;
                        level_reg   <= 1'b1;
                        rep_cnt_reg <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  PRESSED: begin
                     if (!s) begin
                        state_reg <= DEB_RELEASE;
                        cnt_reg   <= '0;
                     end else if (REPEAT_ENABLE) begin
                        rep_cnt_reg <= rep_next;
                        if (rep_next == REP_W'(REPEAT_DELAY)) begin
                           press_reg <= 1'b1;
                        end
                     end
                  end
                  DEB_RELEASE: begin
                     if (s) begin
                        state_reg   <= PRESSED;
                        rep_cnt_reg <= '0;
                     end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_reg <= IDLE;
                        rel_reg   <= 1'b1;
                        level_reg <= 1'b0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end

         assign btn_press[gi]   = press_reg;
         assign btn_release[gi] = rel_reg;
         assign btn_level[gi]   = level_reg;
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Vector-table bench for button_conditioner: one instance without repeat, one with
// REPEAT_DELAY=10 / REPEAT_PERIOD=3, both with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;
   localparam int NB = 5;

   typedef struct {
      logic          rst;
      logic [NB-1:0] btn;
      logic [NB-1:0] lvl;
      logic [NB-1:0] prs;
      logic [NB-1:0] rel;
   } vec_t;

   localparam logic [NB-1:0] Z  = 5'b00000;
   localparam logic [NB-1:0] B0 = 5'b00001;
   localparam logic [NB-1:0] B1 = 5'b00010;
   localparam logic [NB-1:0] B2 = 5'b00100;
   localparam logic [NB-1:0] B04 = 5'b10001;
   localparam logic [NB-1:0] B13 = 5'b01010;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_in, btn_in_r;
   logic [NB-1:0] level_w, press_w, rel_w;
   logic [NB-1:0] level_r, press_r, rel_r;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BTNS(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(10)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_level(level_w), .btn_press(press_w), .btn_release(rel_w)
   );

   button_conditioner #(
      .NUM_BTNS(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_r (
      .clk(clk), .rst(rst), .btn_in(btn_in_r),
      .btn_level(level_r), .btn_press(press_r), .btn_release(rel_r)
   );

   task automatic add(input logic r, input logic [NB-1:0] b, input logic [NB-1:0] l,
                      input logic [NB-1:0] p, input logic [NB-1:0] rl);
      vec_t v;
      v = '{rst: r, btn: b, lvl: l, prs: p, rel: rl};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [NB-1:0] act,
                        input logic [NB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   // Called at a falling edge: drive, queue expectation, sample 1 ns after the rising edge.
   task automatic apply(input vec_t v, input bit sel, input int idx);
      vec_t e;
      rst = v.rst;
      if (sel) btn_in_r = v.btn;
      else     btn_in   = v.btn;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (sel) begin
         check("rep_level",   idx, level_r, e.lvl);
         check("rep_press",   idx, press_r, e.prs);
         check("rep_release", idx, rel_r,   e.rel);
         $display("rep vec %0d btn=%b level=%b press=%b rel=%b", idx, v.btn, level_r, press_r, rel_r);
      end else begin
         check("level",   idx, level_w, e.lvl);
         check("press",   idx, press_w, e.prs);
         check("release", idx, rel_w,   e.rel);
         $display("vec %0d rst=%b btn=%b level=%b press=%b rel=%b", idx, v.rst, v.btn, level_w, press_w, rel_w);
      end
      @(negedge clk);
   endtask

   initial begin
      bit   bounce [7];
      vec_t v;
      bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      rst      = 1'b1;
      btn_in   = Z;
      btn_in_r = Z;

      // Reset state and idle
      for (int k = 0; k < 2; k++) add(1'b1, Z, Z, Z, Z);
      for (int k = 0; k < 3; k++) add(1'b0, Z, Z, Z, Z);
      // Clean press and release on channel 1
      for (int k = 1; k <= 20; k++) add(1'b0, B1, (k >= 7) ? B1 : Z, (k == 7) ? B1 : Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, Z, (k < 7) ? B1 : Z, Z, (k == 7) ? B1 : Z);
      // Bouncing press on channel 2 is rejected
      for (int k = 1; k <= 17; k++) add(1'b0, (k <= 7 && bounce[k-1]) ? B2 : Z, Z, Z, Z);
      // Channel 0: press, one-cycle release glitch, real release
      for (int k = 1; k <= 10; k++) add(1'b0, B0, (k >= 7) ? B0 : Z, (k == 7) ? B0 : Z, Z);
      add(1'b0, Z, B0, Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, B0, B0, Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, Z, (k < 7) ? B0 : Z, Z, (k == 7) ? B0 : Z);
      // Simultaneous channels 0 and 4
      for (int k = 1; k <= 10; k++) add(1'b0, B04, (k >= 7) ? B04 : Z, (k == 7) ? B04 : Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, Z, (k < 7) ? B04 : Z, Z, (k == 7) ? B04 : Z);
      // Reset while channel 1 pressed and channel 3 mid-debounce (cnt=2), both kept held
      for (int k = 1; k <= 8; k++) add(1'b0, B1, (k >= 7) ? B1 : Z, (k == 7) ? B1 : Z, Z);
      for (int k = 1; k <= 5; k++) add(1'b0, B13, B1, Z, Z);
      add(1'b1, B13, Z, Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, B13, (k >= 7) ? B13 : Z, (k == 7) ? B13 : Z, Z);
      for (int k = 1; k <= 10; k++) add(1'b0, Z, (k < 7) ? B13 : Z, Z, (k == 7) ? B13 : Z);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b0, i);

      // Auto-repeat: held from n=1..36; acceptance at n=7 is t=0, so repeats land at
      // t=10,13,... i.e. n=17,20,...; the drop reaches the FSM at edge 39, release at 43.
      for (int n = 1; n <= 50; n++) begin
         v.rst = 1'b0;
         v.btn = (n <= 36) ? B2 : Z;
         v.lvl = (n >= 7 && n <= 42) ? B2 : Z;
         v.prs = (n == 7 || (n >= 17 && n <= 38 && ((n - 17) % 3) == 0)) ? B2 : Z;
         v.rel = (n == 43) ? B2 : Z;
         apply(v, 1'b1, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
